dmem_block_responder: RTL

- Block-granular data-memory responder: the memory side of the data-cache miss/writeback interface.
- Accepts level-held block read (memRen) and block write (memWen) requests from the dcache controller.
- Models main-memory access latency with a down-counter and answers each request with a one-cycle memReadReady or memWriteDone pulse.
- Holds the backing block array, so the cache miss path is closed end-to-end in simulation and on FPGA.

---
 rtl/dmem_block_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_block_responder.sv
// ---------------------------------------------------------------------------
// dmem_block_responder
//
// Memory side of the data-cache miss/writeback interface. Accepts one
// level-held block request at a time, models main-memory latency with an
// 8-bit down-counter, and answers with a single-cycle completion pulse.
// Owns the backing block array so the miss path closes end-to-end.
//
// Handshake: the requester raises memRen or memWen (with BlockAddr/memDin
// valid) and holds it until the matching pulse (memReadReady/memWriteDone).
// The request is taken only in IDLE, address/data are captured at that edge,
// and nothing presented later affects the in-flight operation. Requests are
// ignored while the pulse is up, so a held request is not taken twice; a new
// request in the cycle after the pulse is accepted at the end of that cycle.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   memRen       block read request (level, held until memReadReady)
//   memWen       block write request (level, held until memWriteDone)
//   BlockAddr    block address, sampled at acceptance
//   memDin       write block data, sampled at acceptance
//   memReadReady one-cycle pulse; memDout valid in this cycle
//   memWriteDone one-cycle pulse; write commits at the end of this cycle
//   memDout      read data, held until the next read completes
//   busy         high whenever the FSM is not IDLE
//   dbg_state_o  current FSM state (IDLE/RD_BUSY/WR_BUSY/RESP)
// ---------------------------------------------------------------------------
module dmem_block_responder #(
  parameter int ADDR_W        = 10,
  parameter int BLOCK_BITS    = 128,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRen,
  input  logic                  memWen,
  input  logic [ADDR_W-1:0]     BlockAddr,
  input  logic [BLOCK_BITS-1:0] memDin,
  output logic                  memReadReady,
  output logic                  memWriteDone,
  output logic [BLOCK_BITS-1:0] memDout,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_BUSY = 2'd1;
  localparam logic [1:0] WR_BUSY = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  // The busy state is entered one cycle after acceptance and RESP costs one
  // more cycle, hence the "-2" preload to land the pulse at T+LATENCY.
  localparam logic [7:0] RD_INIT = 8'(READ_LATENCY - 2);
  localparam logic [7:0] WR_INIT = 8'(WRITE_LATENCY - 2);

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  op_is_write_q, op_is_write_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BLOCK_BITS-1:0] data_q, data_d;
  logic                  rd_pulse_q, wr_pulse_q;
  logic [BLOCK_BITS-1:0] dout_q;

  logic [BLOCK_BITS-1:0] mem_q [2**ADDR_W];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_is_write_d = op_is_write_q;
    addr_d        = addr_q;
    data_d        = data_q;
    case (state_q)
      IDLE: begin
        // Write has priority; a simultaneous read is dropped and must be
        // re-requested by the cache after memWriteDone.
        if (memWen) begin
          addr_d        = BlockAddr;
          data_d        = memDin;
          op_is_write_d = 1'b1;
          cnt_d         = WR_INIT;
          state_d       = WR_BUSY;
        end else if (memRen) begin
          addr_d        = BlockAddr;
          op_is_write_d = 1'b0;
          cnt_d         = RD_INIT;
          state_d       = RD_BUSY;
        end
      end
      RD_BUSY, WR_BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      op_is_write_q <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      rd_pulse_q    <= 1'b0;
      wr_pulse_q    <= 1'b0;
      dout_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_is_write_q <= op_is_write_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      // Pulses are registered so they come straight off flops.
      rd_pulse_q    <= (state_d == RESP) && !op_is_write_d;
      wr_pulse_q    <= (state_d == RESP) && op_is_write_d;
      // Read port: sample the array on the edge leaving RD_BUSY.
      if ((state_q == RD_BUSY) && (cnt_q == 8'd0)) begin
        dout_q <= mem_q[addr_q];
      end
    end
  end

  // Write port: commit on the edge leaving RESP. Reset forces state_q to
  // IDLE immediately, so an interrupted write never reaches the array.
  always_ff @(posedge clock) begin
    if ((state_q == RESP) && op_is_write_q) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign memReadReady = rd_pulse_q;
  assign memWriteDone = wr_pulse_q;
  assign memDout      = dout_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule
